// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared types and constants for the mem_responder block.
//            It holds the FSM state encoding, the word geometry and the
//            latency counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          WORD_BYTES = 8;
  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int          CNT_W      = 4;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/response handshake bundle between a fetch/LSU initiator
//            and mem_responder.
// Ports    : req_valid/req_ready/req_wen/req_addr/req_wdata/req_wmask,
//            resp_valid/resp_ready/resp_rdata/resp_err
//            modport master = initiator side, modport slave = responder side
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_store.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_store
// Purpose  : Backing store for mem_responder. One access per 'en' pulse; the
//            read result and the error flag are registered on that edge and
//            held until the next access.
//            Macro MEM_RESPONDER_DPI_EN: when defined, the store is a sparse
//            word model addressed by the full aligned address and err is
//            tied to 0; otherwise it is an internal DEPTH_WORDS x 64 array
//            with range checking.
// Ports    : clk, rst_n       - clock / async active-low reset
//            en, wen          - access strobe, 1 = write
//            addr, wdata      - byte address (bits [2:0] ignored), write data
//            wmask            - byte enables
//            rdata, err       - registered read data / out-of-range flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder_store
  import mem_responder_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wen,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        err
);

`ifdef MEM_RESPONDER_DPI_EN
  logic [63:0] vmem_q [longint];
  longint      vmem_key;
  logic [63:0] vmem_old;
  logic [63:0] vmem_new;
  logic [63:0] rdata_q;

  always_comb begin
    vmem_key = longint'((addr & ALIGN_MASK) >> 3);
    vmem_old = vmem_q.exists(vmem_key) ? vmem_q[vmem_key] : 64'd0;
    vmem_new = vmem_old;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wmask[i]) vmem_new[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (en && wen) begin
      vmem_q[vmem_key] <= vmem_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en) begin
      rdata_q <= wen ? 64'd0 : vmem_old;
    end
  end

  assign rdata = rdata_q;
  assign err   = 1'b0;
`else
  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'(WORD_BYTES);

  logic [63:0]      mem_q [DEPTH_WORDS];
  logic [63:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  // Offset is taken from the aligned address so that the low bits of the
  // byte address never influence the word index.
  assign off      = (addr & ALIGN_MASK) - ADDR_BASE;
  assign in_range = (addr >= ADDR_BASE) && (off < LIMIT);
  assign idx      = off[IDX_W+2:3];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && wen && in_range) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wmask[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (en) begin
      err_d   = ~in_range;
      rdata_d = (wen || !in_range) ? 64'd0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder. Accepts one request at a time, performs
//            the 64-bit read or byte-masked write LATENCY cycles later and
//            presents the result until the initiator takes it.
//            Macro MEM_RESPONDER_DPI_EN selects the DPI backing store (see
//            mem_responder_store); undefined gives the internal array.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_responder_if.slave request/response handshake
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          LATENCY     = 1,
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wen_q, wen_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [7:0]       wmask_q, wmask_d;
  logic             commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Access happens on the acceptance edge itself.
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);

  // The _d copies equal the latched fields in BUSY and the live request in
  // IDLE, which covers the single-cycle latency case without a separate mux.
  mem_responder_store #(
    .ADDR_BASE   (ADDR_BASE),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .wen   (wen_d),
    .addr  (addr_d),
    .wdata (wdata_d),
    .wmask (wmask_d),
    .rdata (bus.resp_rdata),
    .err   (bus.resp_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. One instance with
//            LATENCY=3 covers reads, masked writes, backpressure, range
//            errors and reset mid-transaction; a second with LATENCY=1
//            covers back-to-back streaming.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT3  = 3;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if if3 ();
  mem_responder_if if1 ();

  mem_responder #(.LATENCY(LAT3), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );
  mem_responder #(.LATENCY(1), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  exp_t        sb [$];
  logic [63:0] model [longint];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_rd(input logic [63:0] a);
    longint key;
    key = longint'(a >> 3);
    return model.exists(key) ? model[key] : 64'd0;
  endfunction

  // Present a request to the LATENCY=3 instance and push its expectation.
  task automatic req3(input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask);
    exp_t e;
    e.err   = ~in_range(addr);
    e.rdata = (!wen && in_range(addr)) ? model_rd(addr) : 64'd0;
    e.cyc   = 0;
    sb.push_back(e);
    check("ready_idle", 64'(if3.req_ready), 64'd1);
    if3.req_valid = 1'b1;
    if3.req_wen   = wen;
    if3.req_addr  = addr;
    if3.req_wdata = wdata;
    if3.req_wmask = wmask;
    @(posedge clk); #1;
    // Scramble the fields; the DUT must use what it latched.
    if3.req_valid = 1'b0;
    if3.req_wen   = ~wen;
    if3.req_addr  = ~addr;
    if3.req_wdata = ~wdata;
    if3.req_wmask = ~wmask;
  endtask

  task automatic wait_cmp3();
    int   k;
    exp_t e;
    k = 0;
    while (!if3.resp_valid && k < 20) begin
      check("ready_busy", 64'(if3.req_ready), 64'd0);
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k), 64'(LAT3 - 1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rdata", if3.resp_rdata, e.rdata);
      check("err", 64'(if3.resp_err), 64'(e.err));
    end else begin
      n_bad++;
      $display("FAIL sb_empty: response with no expectation queued");
    end
  endtask

  task automatic finish3(input int stall, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask);
    logic [63:0] held_d;
    logic        held_e;
    held_d = if3.resp_rdata;
    held_e = if3.resp_err;
    repeat (stall) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(if3.resp_valid), 64'd1);
      check("hold_rdata", if3.resp_rdata, held_d);
      check("hold_err", 64'(if3.resp_err), 64'(held_e));
      check("stall_ready", 64'(if3.req_ready), 64'd0);
    end
    if3.resp_ready = 1'b1;
    @(posedge clk); #1;
    if3.resp_ready = 1'b0;
    check("valid_drop", 64'(if3.resp_valid), 64'd0);
    check("ready_back", 64'(if3.req_ready), 64'd1);
    if (wen && in_range(addr)) model[longint'(addr >> 3)] = merge(model_rd(addr), wdata, wmask);
  endtask

  task automatic txn3(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask, input int stall);
    req3(wen, addr, wdata, wmask);
    wait_cmp3();
    finish3(stall, wen, addr, wdata, wmask);
  endtask

  function automatic logic [63:0] sval(input int i);
    return 64'h0123_4567_89AB_CDEF ^ (64'(i + 1) * 64'h0101_0101_0101_0101);
  endfunction

  task automatic drive1(input int i);
    if1.req_valid = 1'b1;
    if1.req_wen   = (i < 4);
    if1.req_addr  = (i < 4) ? BASE + 64'(8 * i) : BASE + 64'(8 * (i - 4)) + 64'(i & 7);
    if1.req_wdata = (i < 4) ? sval(i) : ~sval(i);
    if1.req_wmask = (i < 4) ? 8'hFF : 8'h00;
  endtask

  initial begin
    exp_t e;
    int   c, i, done;
    logic acc;

    rst_n = 1'b0;
    {if3.req_valid, if3.req_wen, if3.resp_ready} = 3'b000;
    {if1.req_valid, if1.req_wen, if1.resp_ready} = 3'b000;
    if3.req_addr = '0; if3.req_wdata = '0; if3.req_wmask = '0;
    if1.req_addr = '0; if1.req_wdata = '0; if1.req_wmask = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(if3.req_ready), 64'd1);
    check("rst_valid", 64'(if3.resp_valid), 64'd0);
    check("rst_rdata", if3.resp_rdata, 64'd0);
    check("rst_err", 64'(if3.resp_err), 64'd0);
    check("rst_ready1", 64'(if1.req_ready), 64'd1);
    check("rst_valid1", 64'(if1.resp_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload, then read with unaligned low bits.
    txn3(1'b1, BASE, 64'h0000_0013_0000_0093, 8'hFF, 0);
    txn3(1'b0, BASE + 64'd4, 64'd0, 8'h00, 0);

    // Masked write, then a zero-mask no-op write.
    txn3(1'b1, BASE + 64'd8, 64'd0, 8'hFF, 0);
    txn3(1'b1, BASE + 64'd8, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 0);
    txn3(1'b0, BASE + 64'd8, 64'd0, 8'h00, 0);
    check("masked_const", model_rd(BASE + 64'd8), 64'h0000_0000_EEFF_0011);
    txn3(1'b1, BASE + 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    txn3(1'b0, BASE + 64'd8, 64'd0, 8'h00, 0);

    // Backpressure on a read.
    txn3(1'b0, BASE, 64'd0, 8'h00, 5);

    // Range boundaries: both out-of-range writes alias onto real words if
    // not suppressed (first and last index).
    txn3(1'b1, BASE + 64'h7FF8, 64'h5555_AAAA_1234_FEDC, 8'hFF, 0);
    txn3(1'b1, BASE + 64'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    txn3(1'b1, BASE - 64'd8,    64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    txn3(1'b0, BASE - 64'd8,    64'd0, 8'h00, 0);
    txn3(1'b0, BASE + 64'h8000, 64'd0, 8'h00, 2);
    txn3(1'b0, BASE + 64'h7FF8, 64'd0, 8'h00, 0);
    txn3(1'b0, BASE,            64'd0, 8'h00, 0);

    // Reset while a write is counting down: the write must be lost.
    if3.req_valid = 1'b1; if3.req_wen = 1'b1; if3.req_addr = BASE + 64'd8;
    if3.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; if3.req_wmask = 8'hFF;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_ready", 64'(if3.req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(if3.req_ready), 64'd1);
    check("arst_valid", 64'(if3.resp_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn3(1'b0, BASE + 64'd8, 64'd0, 8'h00, 0);

    // Reset while a response is being presented.
    req3(1'b0, BASE, 64'd0, 8'h00);
    wait_cmp3();
    rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(if3.resp_valid), 64'd0);
    check("arst_resp_rdata", if3.resp_rdata, 64'd0);
    check("arst_resp_ready", 64'(if3.req_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1 streaming: 4 writes then 4 reads, resp_ready held high.
    if1.resp_ready = 1'b1;
    c = 0; i = 0; done = 0;
    drive1(0);
    while (done < 8 && c < 40) begin
      @(negedge clk);
      if (if1.resp_valid) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("s_rdata", if1.resp_rdata, e.rdata);
          check("s_err", 64'(if1.resp_err), 64'(e.err));
          check("s_resp_cyc", 64'(c), 64'(e.cyc));
        end else begin
          n_bad++;
          $display("FAIL s_sb_empty: response in cycle %0d with nothing queued", c);
        end
        done++;
      end
      acc = if1.req_valid && if1.req_ready;
      if (acc) begin
        check("s_acc_cyc", 64'(c), 64'(2 * i));
        e.rdata = (i < 4) ? 64'd0 : sval(i - 4);
        e.err   = 1'b0;
        e.cyc   = c + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      c++;
      if (acc) begin
        i++;
        if (i < 8) drive1(i);
        else if1.req_valid = 1'b0;
      end
    end
    check("s_done", 64'(done), 64'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
